composer_nlayer: RTL and testbench

- Parametrised successor of the two-layer display composer.
- Merges NUM_LAYERS tile/bitmap line buffers and one sprite line buffer with programmable sprite depth over the layer stack.
- Generates scaled line-buffer read indices, line render starts, line IRQ and field tracking, and produces a registered pixel for the video output stage.
- Sits between the layer/sprite renderers and the display timing/DAC path.

---
 rtl/composer_nlayer.sv | 171 +++++++++++++++++
 tb/tb_composer_nlayer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/composer_nlayer.sv
// Display composer: merges NUM_LAYERS background line buffers with a depth-sorted
// sprite line, tracks beam position/field, and drives scaled renderer indices.
module composer_nlayer #(
  parameter int                 NUM_LAYERS  = 2,
  parameter int                 COLOR_W     = 8,
  parameter int                 ZW          = 2,
  parameter int                 CLK_DIV     = 2,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             interlaced,
  input  logic [7:0]                       frac_x_incr,
  input  logic [7:0]                       frac_y_incr,
  input  logic [COLOR_W-1:0]               border_color,
  input  logic [9:0]                       active_hstart,
  input  logic [9:0]                       active_hstop,
  input  logic [8:0]                       active_vstart,
  input  logic [8:0]                       active_vstop,
  input  logic [9:0]                       irqline,
  input  logic [NUM_LAYERS-1:0]            layer_enabled,
  input  logic                             sprites_enabled,
  output logic                             current_field,
  output logic                             line_irq,
  output logic [9:0]                       scanline,
  output logic [8:0]                       line_idx,
  output logic                             line_render_start,
  output logic [9:0]                       lb_rdidx,
  input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_lb_rddata,
  input  logic [COLOR_W+ZW-1:0]            sprite_lb_rddata,
  output logic                             sprite_lb_erase_start,
  input  logic                             display_next_frame,
  input  logic                             display_next_line,
  input  logic                             display_next_pixel,
  input  logic                             display_current_field,
  output logic [COLOR_W-1:0]               display_data
);

  logic               r_tick;
  logic               w_tick;
  logic [9:0]         r_y;
  logic [9:0]         r_y_d;
  logic [10:0]        r_x;
  logic               r_field;
  logic               r_line_irq;
  logic               r_next_line_d;
  logic               r_vstarted;
  logic               r_render_start;
  logic [15:0]        r_sy;
  logic [16:0]        r_sx;
  logic               r_disp_active;
  logic [COLOR_W-1:0] r_data;

  logic [9:0]         w_x;
  logic               w_hactive;
  logic               w_vactive;
  logic [8:0]         w_line_idx;
  logic [9:0]         w_rdidx;
  logic [15:0]        w_fy_step;
  logic [16:0]        w_fx_step;
  logic [ZW-1:0]      w_spr_z;
  logic [COLOR_W-1:0] w_spr_col;
  logic               w_spr_vis;
  logic [COLOR_W-1:0] w_comp;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tick <= 1'b0;
    else     r_tick <= ~r_tick;
  end

  assign w_tick = (CLK_DIV == 1) ? 1'b1 : r_tick;

  assign w_x        = r_x[10:1];
  assign w_hactive  = (w_x >= active_hstart) && (w_x < active_hstop);
  assign w_vactive  = (r_y_d >= {1'b0, active_vstart}) && (r_y_d < {1'b0, active_vstop});
  assign w_line_idx = r_sy[15:7];
  assign w_rdidx    = r_sx[16:7];
  assign w_fy_step  = interlaced ? {7'd0, frac_y_incr, 1'b0} : {8'd0, frac_y_incr};
  assign w_fx_step  = interlaced ? {10'd0, frac_x_incr[7:1]} : {9'd0, frac_x_incr};

  // Beam position, field and line IRQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y           <= '0;
      r_y_d         <= '0;
      r_x           <= '0;
      r_field       <= 1'b0;
      r_line_irq    <= 1'b0;
      r_next_line_d <= 1'b0;
    end else if (w_tick) begin
      if (display_next_frame) begin
        r_y     <= (interlaced && !display_current_field) ? 10'd1 : 10'd0;
        r_field <= !display_current_field;
      end else if (display_next_line) begin
        r_y <= r_y + (interlaced ? 10'd2 : 10'd1);
      end
      if (display_next_line) r_y_d <= r_y;
      if (display_next_line)       r_x <= '0;
      else if (display_next_pixel) r_x <= r_x + (interlaced ? 11'd1 : 11'd2);
      r_line_irq    <= display_next_line &&
                       (interlaced ? (r_y[9:1] == irqline[9:1]) : (r_y == irqline));
      r_next_line_d <= display_next_line;
    end
  end

  // Source line / read index scaling, evaluated one tick after the line strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vstarted     <= 1'b0;
      r_render_start <= 1'b0;
      r_sy           <= '0;
      r_sx           <= '0;
    end else if (w_tick) begin
      r_render_start <= 1'b0;
      if (r_next_line_d) begin
        if (!r_vstarted && (r_y >= {1'b0, active_vstart})) begin
          r_vstarted     <= 1'b1;
          r_render_start <= 1'b1;
          r_sy <= (interlaced && (r_field ^ active_vstart[0])) ? {8'd0, frac_y_incr} : 16'd0;
        end else if ((w_line_idx < 9'd480) && w_vactive) begin
          r_sy           <= r_sy + w_fy_step;
          r_render_start <= 1'b1;
        end
      end
      if (display_next_frame) r_vstarted <= 1'b0;
      if (display_next_line) begin
        r_sx <= '0;
      end else if (display_next_pixel && w_hactive && (w_rdidx < 10'd640)) begin
        r_sx <= r_sx + w_fx_step;
      end
    end
  end

  assign w_spr_z   = sprite_lb_rddata[COLOR_W +: ZW];
  assign w_spr_col = sprite_lb_rddata[COLOR_W-1:0];
  assign w_spr_vis = sprites_enabled && (w_spr_col != TRANSPARENT);

  // NOTE: w_comp gets a default before the loop so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    w_comp = TRANSPARENT;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (w_spr_vis && (int'(w_spr_z) == k + 1)) w_comp = w_spr_col;
      if (layer_enabled[k] && (layer_lb_rddata[k*COLOR_W +: COLOR_W] != TRANSPARENT))
        w_comp = layer_lb_rddata[k*COLOR_W +: COLOR_W];
    end
    if (w_spr_vis && (int'(w_spr_z) >= NUM_LAYERS + 1)) w_comp = w_spr_col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_active <= 1'b0;
      r_data        <= '0;
    end else if (w_tick) begin
      r_disp_active <= w_hactive && w_vactive;
      r_data        <= r_disp_active ? w_comp : border_color;
    end
  end

  assign current_field         = r_field;
  assign line_irq              = r_line_irq;
  assign scanline              = r_y;
  assign line_idx              = w_line_idx;
  assign line_render_start     = r_render_start;
  assign lb_rdidx              = w_rdidx;
  assign sprite_lb_erase_start = (r_x == {10'd639, interlaced});
  assign display_data          = r_data;

endmodule

// File: tb/tb_composer_nlayer.sv
// Directed bench for composer_nlayer: a 2-layer and a 4-layer instance share the
// timing stimulus; each strobe is held for two clks so it spans exactly one tick.
module tb_composer_nlayer;

  logic        clk = 1'b0;
  logic        rst;
  logic        interlaced;
  logic [7:0]  frac_x_incr, frac_y_incr;
  logic [7:0]  border_color;
  logic [9:0]  active_hstart, active_hstop;
  logic [8:0]  active_vstart, active_vstop;
  logic [9:0]  irqline;
  logic        sprites_enabled;
  logic        display_next_frame, display_next_line, display_next_pixel;
  logic        display_current_field;

  logic [1:0]  layer_enabled_a;
  logic [15:0] layer_rd_a;
  logic [9:0]  sprite_rd_a;
  logic        current_field_a, line_irq_a, render_a, erase_a;
  logic [9:0]  scanline_a, lb_rdidx_a;
  logic [8:0]  line_idx_a;
  logic [7:0]  data_a;

  logic [3:0]  layer_enabled_b;
  logic [31:0] layer_rd_b;
  logic [10:0] sprite_rd_b;
  logic        current_field_b, line_irq_b, render_b, erase_b;
  logic [9:0]  scanline_b, lb_rdidx_b;
  logic [8:0]  line_idx_b;
  logic [7:0]  data_b;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  composer_nlayer #(.NUM_LAYERS(2), .COLOR_W(8), .ZW(2), .CLK_DIV(2), .TRANSPARENT(8'h00)) dut_a (
    .clk(clk), .rst(rst), .interlaced(interlaced),
    .frac_x_incr(frac_x_incr), .frac_y_incr(frac_y_incr), .border_color(border_color),
    .active_hstart(active_hstart), .active_hstop(active_hstop),
    .active_vstart(active_vstart), .active_vstop(active_vstop),
    .irqline(irqline), .layer_enabled(layer_enabled_a), .sprites_enabled(sprites_enabled),
    .current_field(current_field_a), .line_irq(line_irq_a), .scanline(scanline_a),
    .line_idx(line_idx_a), .line_render_start(render_a), .lb_rdidx(lb_rdidx_a),
    .layer_lb_rddata(layer_rd_a), .sprite_lb_rddata(sprite_rd_a),
    .sprite_lb_erase_start(erase_a),
    .display_next_frame(display_next_frame), .display_next_line(display_next_line),
    .display_next_pixel(display_next_pixel), .display_current_field(display_current_field),
    .display_data(data_a)
  );

  composer_nlayer #(.NUM_LAYERS(4), .COLOR_W(8), .ZW(3), .CLK_DIV(2), .TRANSPARENT(8'h00)) dut_b (
    .clk(clk), .rst(rst), .interlaced(interlaced),
    .frac_x_incr(frac_x_incr), .frac_y_incr(frac_y_incr), .border_color(border_color),
    .active_hstart(active_hstart), .active_hstop(active_hstop),
    .active_vstart(active_vstart), .active_vstop(active_vstop),
    .irqline(irqline), .layer_enabled(layer_enabled_b), .sprites_enabled(sprites_enabled),
    .current_field(current_field_b), .line_irq(line_irq_b), .scanline(scanline_b),
    .line_idx(line_idx_b), .line_render_start(render_b), .lb_rdidx(lb_rdidx_b),
    .layer_lb_rddata(layer_rd_b), .sprite_lb_rddata(sprite_rd_b),
    .sprite_lb_erase_start(erase_b),
    .display_next_frame(display_next_frame), .display_next_line(display_next_line),
    .display_next_pixel(display_next_pixel), .display_current_field(display_current_field),
    .display_data(data_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two clks always contain exactly one tick edge (the second, given alignment).
  task automatic step();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic f, input logic l, input logic p);
    display_next_frame = f;
    display_next_line  = l;
    display_next_pixel = p;
    step();
    display_next_frame = 1'b0;
    display_next_line  = 1'b0;
    display_next_pixel = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    interlaced = 1'b0;
    frac_x_incr = 8'd128;
    frac_y_incr = 8'd128;
    border_color = 8'h5A;
    active_hstart = 10'd0;   active_hstop = 10'd640;
    active_vstart = 9'd0;    active_vstop = 9'd480;
    irqline = 10'h3FF;
    sprites_enabled = 1'b1;
    display_next_frame = 1'b0; display_next_line = 1'b0; display_next_pixel = 1'b0;
    display_current_field = 1'b0;
    layer_enabled_a = 2'b11;  layer_rd_a = {8'h22, 8'h11};   sprite_rd_a = {2'd1, 8'h33};
    layer_enabled_b = 4'hF;   layer_rd_b = {8'h04, 8'h03, 8'h02, 8'h01}; sprite_rd_b = {3'd3, 8'h33};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Build up some mid-frame state, then reset asynchronously.
    strobe(1'b1, 1'b0, 1'b0);
    repeat (3) strobe(1'b0, 1'b1, 1'b0);
    check("pre_rst_scanline", 32'(scanline_a), 32'd3);
    check("pre_rst_field", 32'(current_field_a), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_scanline", 32'(scanline_a), 32'd0);
    check("rst_field", 32'(current_field_a), 32'd0);
    check("rst_render", 32'(render_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First edge after release is the non-tick phase.
    display_next_frame = 1'b1;
    display_current_field = 1'b0;
    @(posedge clk); #1;
    check("tick_phase0_field", 32'(current_field_a), 32'd0);
    @(posedge clk); #1;
    display_next_frame = 1'b0;
    check("frame_field", 32'(current_field_a), 32'd1);
    check("frame_scanline", 32'(scanline_a), 32'd0);

    // Vertical scaling: frac 128 gives one source line per display line.
    for (int i = 0; i < 3; i++) begin
      strobe(1'b0, 1'b1, 1'b0);
      step();
      check("line_idx", 32'(line_idx_a), 32'(i));
      check("render_pulse", 32'(render_a), 32'd1);
      step();
      check("render_one_tick", 32'(render_a), 32'd0);
    end
    active_vstop = 9'd511;
    pulses = 0;
    for (int i = 0; i < 478; i++) begin
      strobe(1'b0, 1'b1, 1'b0);
      step();
      if (render_a) pulses++;
    end
    check("render_count", 32'(pulses), 32'd478);
    check("line_idx_480", 32'(line_idx_a), 32'd480);
    strobe(1'b0, 1'b1, 1'b0);
    step();
    check("no_render_at_480", 32'(render_a), 32'd0);
    check("line_idx_held", 32'(line_idx_a), 32'd480);
    active_vstop = 9'd480;

    // Frame and line in the same tick: frame wins.
    strobe(1'b1, 1'b1, 1'b0);
    check("frame_wins_y", 32'(scanline_a), 32'd0);
    strobe(1'b0, 1'b1, 1'b0);

    // Compose, 2 layers: {z} -> expected.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] zs [4];
      logic [7:0] ex_on [4];
      logic [7:0] ex_off [4];
      zs = '{2'd1, 2'd2, 2'd3, 2'd0};
      ex_on = '{8'h22, 8'h22, 8'h33, 8'h22};
      ex_off = '{8'h11, 8'h33, 8'h33, 8'h11};
      sprite_rd_a = {zs[i], 8'h33};
      layer_enabled_a = 2'b11;
      step(); step();
      check("compose2_all", 32'(data_a), 32'(ex_on[i]));
      layer_enabled_a = 2'b01;
      step(); step();
      check("compose2_l1_off", 32'(data_a), 32'(ex_off[i]));
    end
    layer_enabled_a = 2'b11;
    sprite_rd_a = {2'd3, 8'h33};
    sprites_enabled = 1'b0;
    step(); step();
    check("compose2_spr_off", 32'(data_a), 32'h22);
    sprites_enabled = 1'b1;
    sprite_rd_a = {2'd3, 8'h00};
    step(); step();
    check("compose2_spr_transp", 32'(data_a), 32'h22);

    // Compose, 4 layers.
    check("compose4_z3", 32'(data_b), 32'h04);
    layer_rd_b = {8'h00, 8'h00, 8'h02, 8'h01};
    step(); step();
    check("compose4_z3_upper_clear", 32'(data_b), 32'h33);
    layer_rd_b = {8'h04, 8'h03, 8'h02, 8'h01};
    sprite_rd_b = {3'd7, 8'h33};
    step(); step();
    check("compose4_z7", 32'(data_b), 32'h33);

    // Outside the horizontal window the border is shown.
    active_hstart = 10'd10; active_hstop = 10'd20;
    step(); step();
    check("border_a", 32'(data_a), 32'h5A);
    check("border_b", 32'(data_b), 32'h5A);
    active_hstart = 10'd0; active_hstop = 10'd640;

    // Horizontal scaling at half rate.
    frac_x_incr = 8'd64;
    strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("lb_rdidx", 32'(lb_rdidx_a), 32'(i / 2));
      strobe(1'b0, 1'b0, 1'b1);
    end

    // Sprite erase request at x = 639.
    strobe(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 638; i++) strobe(1'b0, 1'b0, 1'b1);
    check("erase_638", 32'(erase_a), 32'd0);
    strobe(1'b0, 1'b0, 1'b1);
    check("erase_639", 32'(erase_a), 32'd1);
    strobe(1'b0, 1'b0, 1'b1);
    check("erase_640", 32'(erase_a), 32'd0);

    // Interlaced line IRQ compares y[9:1].
    interlaced = 1'b1;
    irqline = 10'h0A1;
    display_current_field = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    check("ilace_field0_y", 32'(scanline_a), 32'd1);
    display_current_field = 1'b1;
    strobe(1'b1, 1'b0, 1'b0);
    check("ilace_field1_y", 32'(scanline_a), 32'd0);
    check("ilace_field1_cf", 32'(current_field_a), 32'd0);
    for (int i = 0; i < 80; i++) strobe(1'b0, 1'b1, 1'b0);
    check("ilace_y_a0", 32'(scanline_a), 32'h0A0);
    strobe(1'b0, 1'b1, 1'b0);
    check("ilace_irq", 32'(line_irq_a), 32'd1);
    step();
    check("ilace_irq_clear", 32'(line_irq_a), 32'd0);

    // Non-interlaced needs an exact match.
    interlaced = 1'b0;
    strobe(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 160; i++) strobe(1'b0, 1'b1, 1'b0);
    check("prog_y_a0", 32'(scanline_a), 32'h0A0);
    strobe(1'b0, 1'b1, 1'b0);
    check("prog_no_irq", 32'(line_irq_a), 32'd0);
    strobe(1'b0, 1'b1, 1'b0);
    check("prog_irq_a1", 32'(line_irq_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
